// File: rtl/demux1x2_deser.sv
// 1-bit to N-bit deserializer tracking the upstream mux select; publishes each completed frame with a one-cycle strobe.
// Optional parity beat per frame when DEMUX_DESER_PARITY_EN is defined.
module demux1x2_deser #(
    parameter int N  = 2,
    parameter int SW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_valid,
    input  logic          frame_start,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    output logic [SW-1:0] sel,
    output logic          busy,
`ifdef DEMUX_DESER_PARITY_EN
    output logic          parity_err,
`endif
    output logic          frame_err
);

`ifdef DEMUX_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

    state_t        state, state_n;
    logic [SW-1:0] sel_n;
    logic [N-1:0]  shadow, shadow_n;
    logic [N-1:0]  dout_n;
    logic          dv_n;
    logic          fe_n;
    logic          last;
`ifdef DEMUX_DESER_PARITY_EN
    logic          pe_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef DEMUX_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            shadow     <= shadow_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
            frame_err  <= fe_n;
`ifdef DEMUX_DESER_PARITY_EN
            parity_err <= pe_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel;
        shadow_n = shadow;
        dout_n   = dout;
        dv_n     = 1'b0;
        fe_n     = 1'b0;
        last     = 1'b0;
`ifdef DEMUX_DESER_PARITY_EN
        pe_n     = 1'b0;
`endif
        if (din_valid) begin
            // A frame_start beat always opens a new frame; outside IDLE it also aborts the current one.
            if (frame_start) begin
                fe_n        = (state != IDLE);
                shadow_n    = '0;
                shadow_n[0] = din;
                last        = (N == 1);
                if (!last) begin
                    sel_n   = SW'(1);
                    state_n = COLLECT;
                end
            end else if (state == COLLECT) begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (sel == SW'(i)) shadow_n[i] = din;
                end
                last = (sel == SW'(N - 1));
                if (!last) sel_n = sel + 1'b1;
            end
`ifdef DEMUX_DESER_PARITY_EN
            else if (state == PARITY) begin
                dout_n  = shadow;
                dv_n    = 1'b1;
                pe_n    = ^{shadow, din};
                sel_n   = '0;
                state_n = IDLE;
            end
`endif
            if (last) begin
`ifdef DEMUX_DESER_PARITY_EN
                sel_n   = SW'(N);
                state_n = PARITY;
`else
                dout_n  = shadow_n;
                dv_n    = 1'b1;
                sel_n   = '0;
                state_n = IDLE;
`endif
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_demux1x2_deser.sv
// Directed table-driven bench for demux1x2_deser (N=2), with hand-written abort, back-to-back and parity sequences.
module tb_demux1x2_deser;
    localparam int N  = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst, din, din_valid, frame_start;
    logic [N-1:0]  dout;
    logic          dout_valid, busy, frame_err;
    logic [SW-1:0] sel;
`ifdef DEMUX_DESER_PARITY_EN
    logic          parity_err;
`endif

    demux1x2_deser #(.N(N), .SW(SW)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .dout(dout), .dout_valid(dout_valid), .sel(sel), .busy(busy),
`ifdef DEMUX_DESER_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic fs, input logic d);
        rst = r; din_valid = v; frame_start = fs; din = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          r, v, fs, d;
        logic [N-1:0]  dout;
        logic          dv;
        logic [SW-1:0] sel;
        logic          busy, fe;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic fs, input logic d,
                       input logic [N-1:0] e_dout, input logic e_dv, input logic [SW-1:0] e_sel,
                       input logic e_busy, input logic e_fe);
        vec_t t;
        t.r = r; t.v = v; t.fs = fs; t.d = d;
        t.dout = e_dout; t.dv = e_dv; t.sel = e_sel; t.busy = e_busy; t.fe = e_fe;
        tbl.push_back(t);
    endtask

    initial begin
        int pulses;
        int fe_pulses;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0;

`ifndef DEMUX_DESER_PARITY_EN
        //   r  v  fs d   dout   dv sel   busy fe
        add(1, 0, 0, 0, 2'b00, 0, 2'd0, 0, 0);   // reset
        add(1, 0, 0, 0, 2'b00, 0, 2'd0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b00, 0, 2'd1, 1, 0);   // basic frame 1,0
        add(0, 1, 0, 0, 2'b01, 1, 2'd0, 0, 0);
        add(0, 0, 0, 0, 2'b01, 0, 2'd0, 0, 0);
        add(0, 1, 1, 0, 2'b01, 0, 2'd1, 1, 0);   // gap frame 0,_,_,_,1
        add(0, 0, 0, 0, 2'b01, 0, 2'd1, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 2'd1, 1, 0);
        add(0, 0, 0, 0, 2'b01, 0, 2'd1, 1, 0);
        add(0, 1, 0, 1, 2'b10, 1, 2'd0, 0, 0);
        add(0, 1, 0, 1, 2'b10, 0, 2'd0, 0, 0);   // idle drops
        add(0, 1, 0, 0, 2'b10, 0, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b10, 0, 2'd1, 1, 0);   // abort
        add(0, 1, 1, 0, 2'b10, 0, 2'd1, 1, 1);
        add(0, 1, 0, 1, 2'b10, 1, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b10, 0, 2'd1, 1, 0);   // back-to-back 11,01,10,00
        add(0, 1, 0, 1, 2'b11, 1, 2'd0, 0, 0);
        add(0, 1, 1, 0, 2'b11, 0, 2'd1, 1, 0);
        add(0, 1, 0, 1, 2'b10, 1, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b10, 0, 2'd1, 1, 0);
        add(0, 1, 0, 0, 2'b01, 1, 2'd0, 0, 0);
        add(0, 1, 1, 0, 2'b01, 0, 2'd1, 1, 0);
        add(0, 1, 0, 0, 2'b00, 1, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b00, 0, 2'd1, 1, 0);   // 11 then reset mid-frame
        add(0, 1, 0, 1, 2'b11, 1, 2'd0, 0, 0);
        add(0, 1, 1, 1, 2'b11, 0, 2'd1, 1, 0);
        add(1, 1, 0, 1, 2'b00, 0, 2'd0, 0, 0);
        add(0, 0, 0, 0, 2'b00, 0, 2'd0, 0, 0);
        add(0, 1, 0, 1, 2'b00, 0, 2'd0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].v, tbl[i].fs, tbl[i].d);
            chk($sformatf("v%0d dout", i), 32'(dout), 32'(tbl[i].dout));
            chk($sformatf("v%0d dout_valid", i), 32'(dout_valid), 32'(tbl[i].dv));
            chk($sformatf("v%0d sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d frame_err", i), 32'(frame_err), 32'(tbl[i].fe));
        end

        // Abort carrying new data: partial 1 discarded, new frame 1,0 -> 01.
        pulses = 0; fe_pulses = 0;
        step(0, 1, 1, 1); fe_pulses += int'(frame_err);
        step(0, 1, 1, 1); fe_pulses += int'(frame_err);
        step(0, 1, 0, 0); fe_pulses += int'(frame_err); pulses += int'(dout_valid);
        chk("abort dout", 32'(dout), 32'(2'b01));
        step(0, 0, 0, 0); fe_pulses += int'(frame_err); pulses += int'(dout_valid);
        chk("abort fe_pulses", 32'(fe_pulses), 32'd1);
        chk("abort dv_pulses", 32'(pulses), 32'd1);

        // Three gap-free frames; count strobes over a bounded window.
        pulses = 0;
        for (int f = 0; f < 3; f++) begin
            step(0, 1, 1, 1'(f));     pulses += int'(dout_valid);
            step(0, 1, 0, 1'(f + 1)); pulses += int'(dout_valid);
        end
        for (int c = 0; c < 4; c++) begin
            step(0, 0, 0, 0); pulses += int'(dout_valid);
        end
        chk("b2b dv_pulses", 32'(pulses), 32'd3);
        chk("b2b last dout", 32'(dout), 32'(2'b10));
        chk("b2b idle sel", 32'(sel), 32'd0);
`else
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst dout_valid", 32'(dout_valid), 32'd0);
        chk("rst sel", 32'(sel), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst parity_err", 32'(parity_err), 32'd0);
        // frame 1,1 parity 0 -> good
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        chk("par sel", 32'(sel), 32'd2);
        chk("par busy", 32'(busy), 32'd1);
        chk("par dv early", 32'(dout_valid), 32'd0);
        step(0, 1, 0, 0);
        chk("par1 dout", 32'(dout), 32'(2'b11));
        chk("par1 dv", 32'(dout_valid), 32'd1);
        chk("par1 perr", 32'(parity_err), 32'd0);
        chk("par1 sel", 32'(sel), 32'd0);
        // frame 1,0 parity 0 -> mismatch
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("par2 dout", 32'(dout), 32'(2'b01));
        chk("par2 dv", 32'(dout_valid), 32'd1);
        chk("par2 perr", 32'(parity_err), 32'd1);
        step(0, 0, 0, 0);
        chk("par2 perr clear", 32'(parity_err), 32'd0);
        // frame_start during the parity beat aborts
        step(0, 1, 1, 1);
        step(0, 1, 0, 1);
        step(0, 1, 1, 0);
        chk("par abort fe", 32'(frame_err), 32'd1);
        chk("par abort dout", 32'(dout), 32'(2'b01));
        chk("par abort sel", 32'(sel), 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
